// File: rtl/fib_chk_pkg.sv
// Shared types and constants for the Fibonacci write-back checker.
package fib_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/fib_term_gen.sv
// Purpose: two-register Fibonacci-style term generator (a, b), term = a.
// Latency: load/advance take effect on the next clock; term is registered.
// Backpressure: none; advances only when told to.
module fib_term_gen
    import fib_chk_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    output logic [DATA_W-1:0] term
);

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;

    // Sum wraps modulo 2^DATA_W by construction.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            a <= seed0;
            b <= seed1;
        end else if (advance) begin
            a <= b;
            b <= a + b;
        end
    end

    assign term = a;

endmodule

// File: rtl/fib_wb_checker.sv
// Purpose: snoops dmem stores, checks in-window writes in order against a generated Fibonacci sequence.
// Latency: compare result on err_cnt_o/term_idx_o one cycle after the write; optional FIB_WB_CHECKER_FIRST_ERR_EN capture.
// Backpressure: none; passive observer, never stalls or drives the memory.
module fib_wb_checker
    import fib_chk_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_TERMS   = 10,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_STRIDE = 4,
    parameter int SEED0       = 1,
    parameter int SEED1       = 2,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_i,
    input  logic                           dmem_we_i,
    input  logic [ADDR_W-1:0]              dmem_addr_i,
    input  logic [DATA_W-1:0]              dmem_wdata_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           pass_o,
    output logic                           timeout_o,
    output logic [$clog2(NUM_TERMS+1)-1:0] term_idx_o,
    output logic [DATA_W-1:0]              exp_o,
    output logic [ERR_CNT_W-1:0]           err_cnt_o,
    output logic [$clog2(NUM_TERMS+1)-1:0] first_err_idx_o,
    output logic [DATA_W-1:0]              first_err_exp_o,
    output logic [DATA_W-1:0]              first_err_act_o
);

    localparam int IDX_W = $clog2(NUM_TERMS+1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC+1);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);
    localparam logic [ADDR_W-1:0] WIN_LEN  = ADDR_W'(NUM_TERMS * ADDR_STRIDE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TERMS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYC);

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [TMO_W-1:0]    cyc_cnt;
    logic                timeout;
    logic [DATA_W-1:0]   exp_term;

    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   exp_addr;
    logic                in_win;
    logic                wr_act;
    logic                hit;
    logic                order_err;
    logic                mismatch;
    logic                err_evt;
    logic                last_hit;
    logic                tmo_hit;

    assign offset   = dmem_addr_i - BASE;
    assign in_win   = (dmem_addr_i >= BASE) && (offset < WIN_LEN) && ((offset % STRIDE) == '0);
    assign exp_addr = BASE + ADDR_W'(idx) * STRIDE;

    // A start in the same cycle as a write discards the write.
    assign wr_act    = (state == CHECK) && dmem_we_i && in_win && !start_i;
    assign hit       = wr_act && (dmem_addr_i == exp_addr);
    assign order_err = wr_act && !hit;
    assign mismatch  = hit && (dmem_wdata_i != exp_term);
    assign err_evt   = order_err || mismatch;
    assign last_hit  = hit && (idx == LAST_IDX);
    assign tmo_hit   = (state == CHECK) && (cyc_cnt == TMO_LAST);

    fib_term_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (start_i),
        .advance (hit),
        .seed0   (DATA_W'(SEED0)),
        .seed1   (DATA_W'(SEED1)),
        .term    (exp_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion takes priority over a timeout landing on the same cycle.
    always_comb begin
        state_nxt = state;
        if (start_i) begin
            state_nxt = CHECK;
        end else begin
            unique case (state)
                CHECK: begin
                    if (last_hit || tmo_hit) begin
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state)
            CHECK:   busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || start_i) begin
            idx     <= '0;
            err_cnt <= '0;
            cyc_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (hit) begin
                idx <= idx + 1'b1;
            end
            if (err_evt && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if ((state == CHECK) && (cyc_cnt != TMO_MAX)) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (tmo_hit && !last_hit) begin
                timeout <= 1'b1;
            end
        end
    end

`ifdef FIB_WB_CHECKER_FIRST_ERR_EN
    logic [IDX_W-1:0]  fe_idx;
    logic [DATA_W-1:0] fe_exp;
    logic [DATA_W-1:0] fe_act;

    // err_cnt is zero only until the first error since start.
    always_ff @(posedge clk) begin
        if (reset || start_i) begin
            fe_idx <= '0;
            fe_exp <= '0;
            fe_act <= '0;
        end else if (err_evt && (err_cnt == '0)) begin
            fe_idx <= idx;
            fe_exp <= exp_term;
            fe_act <= dmem_wdata_i;
        end
    end

    assign first_err_idx_o = fe_idx;
    assign first_err_exp_o = fe_exp;
    assign first_err_act_o = fe_act;
`else
    assign first_err_idx_o = '0;
    assign first_err_exp_o = '0;
    assign first_err_act_o = '0;
`endif

    assign term_idx_o = idx;
    assign exp_o      = exp_term;
    assign err_cnt_o  = err_cnt;
    assign timeout_o  = timeout;
    assign pass_o     = done_o && (err_cnt == '0) && !timeout;

endmodule
